// File: rtl/program_loader.sv
// Boot-time loader: turns a byte stream (16-bit big-endian word count header followed by
// big-endian instruction words) into program-memory writes, then releases the core.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic [15:0] word_count_o,
  output logic        load_done_o,
  output logic        error_o,
  output logic        cpu_run_o
);

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
    StDone,
    StError
  } state_e;

  localparam logic [16:0] MaxWords = 17'(MEMORY_DEPTH);

  state_e      state_q, state_d;
  logic [15:0] n_q;
  logic [23:0] shift_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] word_count_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic [15:0] n_hdr;
  logic [15:0] count_inc;

  assign accept    = byte_valid_i && byte_ready_o;
  assign n_hdr     = {n_q[15:8], byte_i};
  assign count_inc = word_count_q + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StHdrHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StHdrHi: begin
        if (accept) state_d = StHdrLo;
      end
      StHdrLo: begin
        if (accept) begin
          if (n_hdr == 16'd0) begin
            state_d = StDone;
          end else if ({1'b0, n_hdr} > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept && byte_idx_q == 2'd3) state_d = StWrite;
      end
      StWrite: begin
        state_d = (count_inc == n_q) ? StDone : StData;
      end
      default: state_d = state_q;
    endcase
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock.
  always_comb begin
    byte_ready_o = 1'b0;
    imem_we_o    = 1'b0;
    load_done_o  = 1'b0;
    error_o      = 1'b0;
    cpu_run_o    = 1'b0;
    case (state_q)
      StHdrHi, StHdrLo, StData: byte_ready_o = 1'b1;
      StWrite:                  imem_we_o    = 1'b1;
      StDone: begin
        load_done_o = 1'b1;
        cpu_run_o   = 1'b1;
      end
      StError:                  error_o      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q          <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      word_count_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        StHdrHi: begin
          if (accept) n_q[15:8] <= byte_i;
        end
        StHdrLo: begin
          if (accept) begin
            n_q[7:0]     <= byte_i;
            byte_idx_q   <= '0;
            word_count_q <= '0;
          end
        end
        StData: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // Latch the finished word and its address; they hold until the next word completes.
              wdata_q <= {shift_q, byte_i};
              addr_q  <= {14'd0, word_count_q, 2'b00};
            end else begin
              shift_q <= {shift_q[15:0], byte_i};
            end
          end
        end
        StWrite: word_count_q <= count_inc;
        default: ;
      endcase
    end
  end

  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header handling, word assembly, writes, reset and idle.
module tb_program_loader;

  localparam int unsigned Depth = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic [15:0] word_count_o;
  logic        load_done_o;
  logic        error_o;
  logic        cpu_run_o;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_rdy[$];

  program_loader #(.MEMORY_DEPTH(Depth)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .word_count_o (word_count_o),
    .load_done_o  (load_done_o),
    .error_o      (error_o),
    .cpu_run_o    (cpu_run_o)
  );

  always #5 clk = ~clk;

  // Record every write and every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && imem_we_o) begin
      wr_addr.push_back(imem_addr_o);
      wr_data.push_back(imem_wdata_o);
      wr_rdy.push_back(byte_ready_o);
    end
    if (reset && byte_valid_i && byte_ready_o) hs_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_rdy.delete();
    hs_count = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    byte_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_log();
  endtask

  // Returns 1 time unit after the edge that transferred the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    while (!byte_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_byte: ready never rose for byte %h", b);
    end
    @(posedge clk);
    #1 byte_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (byte_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", byte_ready_o);
    end
    checks++;
    if ({imem_we_o, load_done_o, error_o, cpu_run_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {imem_we_o, load_done_o, error_o, cpu_run_o});
    end
    checks++;
    if ({imem_addr_o, imem_wdata_o, word_count_o} !== 80'd0) begin
      failures++;
      $display("FAIL reset_data: addr %h wdata %h count %0d want all 0",
               imem_addr_o, imem_wdata_o, word_count_o);
    end
  endtask

  task automatic test_load_two();
    logic [7:0] hdr[6];
    hdr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_byte(hdr[i]);
      if (i == 1) begin
        checks++;
        if (cpu_run_o !== 1'b0) begin
          failures++; $display("FAIL two_run_early: got %b want 0", cpu_run_o);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({imem_we_o, byte_ready_o, imem_addr_o, imem_wdata_o} !== {2'b10, 32'h0, 32'h20080005}) begin
      failures++;
      $display("FAIL two_write0: we %b rdy %b addr %h data %h want we 1 rdy 0 addr 0 data 20080005",
               imem_we_o, byte_ready_o, imem_addr_o, imem_wdata_o);
    end
    send_byte(8'h21);
    send_byte(8'h29);
    send_byte(8'h00);
    send_byte(8'h03);
    @(negedge clk);
    checks++;
    if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, 32'h4, 32'h21290003}) begin
      failures++;
      $display("FAIL two_write1: we %b addr %h data %h want we 1 addr 4 data 21290003",
               imem_we_o, imem_addr_o, imem_wdata_o);
    end
    @(negedge clk);
    checks++;
    if ({word_count_o, load_done_o, cpu_run_o, byte_ready_o} !== {16'd2, 3'b110}) begin
      failures++;
      $display("FAIL two_done: count %0d done %b run %b rdy %b want 2 1 1 0",
               word_count_o, load_done_o, cpu_run_o, byte_ready_o);
    end
    checks++;
    if (wr_addr.size() != 2 || wr_rdy[0] !== 1'b0 || wr_rdy[1] !== 1'b0) begin
      failures++;
      $display("FAIL two_log: writes %0d want 2 with ready low in each", wr_addr.size());
    end
  endtask

  task automatic test_zero_header();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    checks++;
    if ({load_done_o, cpu_run_o, byte_ready_o, word_count_o} !== {3'b110, 16'd0}) begin
      failures++;
      $display("FAIL zero_done: done %b run %b rdy %b count %0d want 1 1 0 0",
               load_done_o, cpu_run_o, byte_ready_o, word_count_o);
    end
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 0) begin
      failures++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size());
    end
  endtask

  task automatic test_error();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h21);
    @(negedge clk);
    checks++;
    if ({error_o, byte_ready_o, cpu_run_o, load_done_o} !== 4'b1000) begin
      failures++;
      $display("FAIL err_flags: err %b rdy %b run %b done %b want 1 0 0 0",
               error_o, byte_ready_o, cpu_run_o, load_done_o);
    end
    byte_i = 8'h77;
    byte_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (hs_count != 2 || wr_addr.size() != 0 || error_o !== 1'b1) begin
      failures++;
      $display("FAIL err_stuck: handshakes %0d writes %0d err %b want 2 0 1",
               hs_count, wr_addr.size(), error_o);
    end
  endtask

  task automatic test_full_depth();
    logic [31:0] w;
    int bad = 0;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h20);
    for (int k = 0; k < 32; k++) begin
      w = {8'(k), ~8'(k), 8'(k) ^ 8'h5A, 8'hC3};
      for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() != 32) begin
      failures++; $display("FAIL full_count: writes %0d want 32", wr_addr.size());
    end else begin
      for (int k = 0; k < 32; k++) begin
        w = {8'(k), ~8'(k), 8'(k) ^ 8'h5A, 8'hC3};
        if (wr_addr[k] !== 32'(k * 4) || wr_data[k] !== w) bad++;
      end
      checks++;
      if (wr_addr[31] !== 32'h7C) begin
        failures++; $display("FAIL full_last_addr: got %h want 0000007c", wr_addr[31]);
      end
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL full_data: %0d of 32 writes wrong addr/data want 0", bad);
    end
    checks++;
    if ({word_count_o, load_done_o, error_o} !== {16'd32, 2'b10}) begin
      failures++;
      $display("FAIL full_done: count %0d done %b err %b want 32 1 0",
               word_count_o, load_done_o, error_o);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] img[3];
    int gap;
    int bad = 0;
    img = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    do_reset();
    send_byte(8'h00);
    send_byte(8'h03);
    for (int k = 0; k < 3; k++) begin
      for (int b = 3; b >= 0; b--) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        send_byte(img[k][b*8 +: 8]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() != 3) begin
      failures++; $display("FAIL gaps_count: writes %0d want 3", wr_addr.size());
    end else begin
      for (int k = 0; k < 3; k++)
        if (wr_addr[k] !== 32'(k * 4) || wr_data[k] !== img[k]) bad++;
    end
    checks++;
    if (bad != 0 || word_count_o !== 16'd3 || cpu_run_o !== 1'b1) begin
      failures++;
      $display("FAIL gaps_data: bad %0d count %0d run %b want 0 3 1", bad, word_count_o, cpu_run_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq[6];
    seq = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    checks++;
    if (word_count_o !== 16'd1) begin
      failures++; $display("FAIL mid_precount: got %0d want 1", word_count_o);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({imem_we_o, cpu_run_o, byte_ready_o, word_count_o, imem_addr_o} !== {3'b001, 48'd0}) begin
      failures++;
      $display("FAIL mid_async: we %b run %b rdy %b count %0d addr %h want 0 0 1 0 0",
               imem_we_o, cpu_run_o, byte_ready_o, word_count_o, imem_addr_o);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL mid_reload: writes %0d first addr %h data %h want 1 0 aabbccdd",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx,
               (wr_data.size() > 0) ? wr_data[0] : 32'hx);
    end
    checks++;
    if ({load_done_o, cpu_run_o, word_count_o} !== {2'b11, 16'd1}) begin
      failures++;
      $display("FAIL mid_done: done %b run %b count %0d want 1 1 1",
               load_done_o, cpu_run_o, word_count_o);
    end
  endtask

  // Runs straight after test_reset_mid, with the loader sitting in DONE.
  task automatic test_after_done();
    int hs0;
    int wr0;
    hs0 = hs_count;
    wr0 = wr_addr.size();
    byte_i = 8'h55;
    byte_valid_i = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (hs_count != hs0 || wr_addr.size() != wr0) begin
      failures++;
      $display("FAIL done_idle: handshakes %0d writes %0d want %0d %0d",
               hs_count, wr_addr.size(), hs0, wr0);
    end
    checks++;
    if ({word_count_o, cpu_run_o} !== {16'd1, 1'b1}) begin
      failures++;
      $display("FAIL done_hold: count %0d run %b want 1 1", word_count_o, cpu_run_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_zero_header();
    test_error();
    test_full_depth();
    test_gaps();
    test_reset_mid();
    test_after_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader upstream of the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the program memory's write port. It holds the core idle until the whole image is written, then asserts `cpu_run_o`, which releases the core to fetch from address 0.

## Interface
Parameters:
- `MEMORY_DEPTH`, 32: capacity of program memory in 32-bit words; maximum loadable image size.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `byte_i`, input, 8: incoming stream byte.
- `byte_valid_i`, input, 1: `byte_i` is valid this cycle.
- `byte_ready_o`, output, 1: loader accepts a byte this cycle. A byte transfers when valid and ready are both high at a rising edge.
- `imem_we_o`, output, 1: one-cycle write strobe to program memory.
- `imem_addr_o`, output, 32: byte address of the word being written (4·k). Word-aligned, matching PC addressing.
- `imem_wdata_o`, output, 32: instruction word being written.
- `word_count_o`, output, 16: number of words written so far.
- `load_done_o`, output, 1: image fully written; sticky until reset.
- `error_o`, output, 1: header word count exceeds `MEMORY_DEPTH`; sticky until reset.
- `cpu_run_o`, output, 1: high releases the core. Low holds the core in reset.

## Operation
- FSM states: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR. The reset state is HDR_HI.
- HDR_HI: accepting a byte stores it as N[15:8] and moves to HDR_LO.
- HDR_LO: accepting a byte stores it as N[7:0]. The next state depends on N:
  - N == 0: go to DONE.
  - N > `MEMORY_DEPTH`: go to ERROR.
  - Otherwise: go to DATA with byte index 0 and word index 0.
- DATA: each accepted byte shifts into the word register, first byte to bits [31:24]. On the 4th byte of a word, go to WRITE.
- WRITE: lasts exactly one cycle.
  - `imem_we_o`=1, `imem_addr_o`={word index, 2'b00}, `imem_wdata_o`=assembled word.
  - At the edge ending WRITE, the word index and `word_count_o` increment.
  - Next state is DONE if the new count == N, else DATA.
- DONE: `load_done_o`=1 and `cpu_run_o`=1. Further bytes are not accepted.
- ERROR: `error_o`=1. `cpu_run_o` stays 0 and no bytes are accepted. Exit only via reset.
- `byte_ready_o` = 1 in HDR_HI, HDR_LO and DATA; 0 in WRITE, DONE and ERROR. It is combinational from state.
- `imem_addr_o` and `imem_wdata_o` are don't-care when `imem_we_o`=0 but must not be X. They hold their last values.
- The word index never exceeds `MEMORY_DEPTH`-1, because the N check happens before any write.
- The loader never reads program memory and never clears it. Unwritten words keep their prior contents.

## Timing
- Reset values: `byte_ready_o`=1 once reset deasserts. All other outputs are 0: `imem_we_o`, `imem_addr_o`, `imem_wdata_o`, `word_count_o`, `load_done_o`, `error_o`, `cpu_run_o`.
- Reset asserted mid-load: asynchronous return to HDR_HI. The byte and word indices clear, and `imem_we_o`/`cpu_run_o` drop immediately without waiting for `clk`. A partially assembled word is discarded.
- Write latency: the 4th byte is accepted at edge t, and `imem_we_o` is high during cycle t→t+1.
- Throughput: at most 1 byte per cycle in DATA. Each word costs ≥4 accept cycles plus 1 WRITE cycle.
- `byte_valid_i` low inserts idle cycles in any accepting state with no state change.
- `cpu_run_o` rises at the edge ending the final WRITE, or the edge accepting HDR_LO when N=0. It stays high until reset.
- `byte_valid_i` high during WRITE/DONE/ERROR: the byte is not consumed. The source must hold it per the handshake.

## Test plan
- Load N=2, bytes 00 02 20 08 00 05 21 29 00 03 → writes: cycle 1 addr 0x0 data 0x20080005, cycle 2 addr 0x4 data 0x21290003. `word_count_o`=2, then `load_done_o`=`cpu_run_o`=1. `byte_ready_o`=0 during each WRITE cycle.
- Header 00 00 → DONE right after the 2nd byte. No `imem_we_o` pulse, `cpu_run_o`=1, `word_count_o`=0.
- With `MEMORY_DEPTH`=32: header 00 21 (33) → `error_o`=1, `byte_ready_o`=0, `cpu_run_o`=0. Header 00 20 (32) is accepted and the last write lands at addr 0x7C.
- Randomly deassert `byte_valid_i` between bytes of a 3-word image → identical writes and addresses as the gap-free run. No extra `imem_we_o` pulses.
- Assert `reset` after 6 data bytes of N=4 → outputs clear asynchronously. A fresh image 00 01 AA BB CC DD then writes 0xAABBCCDD at addr 0x0.
- After DONE, keep `byte_valid_i`=1 for 10 cycles → no handshake completes, no writes occur, and `word_count_o` is unchanged.
